// File: rtl/zeroriscy_defines.sv
// zeroriscy_defines: LSU FSM states and data-type codes shared by the LSU files.
// ZERORISCY_LSU_MISALIGNED_EN adds the states for split misaligned accesses.
package zeroriscy_defines;

   localparam logic [1:0] DT_WORD = 2'b00;
   localparam logic [1:0] DT_HALF = 2'b01;
   localparam logic [1:0] DT_BYTE = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RVALID
`ifdef ZERORISCY_LSU_MISALIGNED_EN
      ,
      WAIT_GNT_MIS,
      WAIT_RVALID_MIS
`endif
   } lsu_state_e;

endpackage

// File: rtl/zeroriscy_lsu_align.sv
// zeroriscy_lsu_align: byte enables, store-data rotation and load extraction.
// Type code 2'b11 is handled like a word.
module zeroriscy_lsu_align
   import zeroriscy_defines::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  data_type,
   input  logic        sign_ext,
   input  logic        second,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_hi,
   input  logic [31:0] rdata_lo,
   output logic [3:0]  be,
   output logic [31:0] wdata_rot,
   output logic [31:0] rdata_ext
);

   logic [3:0]  mask;
   logic [4:0]  sh;
   logic [31:0] rd;

   always_comb begin
      sh        = {off, 3'b000};
      mask      = data_type == DT_BYTE ? 4'b0001 : data_type == DT_HALF ? 4'b0011 : 4'b1111;
      be        = second ? (data_type == DT_HALF ? 4'b0001 : 4'b1111 >> (3'd4 - {1'b0, off})) : mask << off;
      wdata_rot = (wdata << sh) | (wdata >> (6'd32 - {1'b0, sh}));
      rd        = 32'({rdata_hi, rdata_lo} >> sh);
      rdata_ext = data_type == DT_BYTE ? {{24{sign_ext & rd[7]}}, rd[7:0]} :
                  data_type == DT_HALF ? {{16{sign_ext & rd[15]}}, rd[15:0]} : rd;
   end

endmodule

// File: rtl/zeroriscy_lsu_ctrl.sv
// zeroriscy_lsu_ctrl: load/store unit bus controller, one outstanding transaction.
// ZERORISCY_LSU_MISALIGNED_EN splits misaligned accesses into two bus transfers.
module zeroriscy_lsu_ctrl
   import zeroriscy_defines::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_req_ex_i,
   input  logic        data_we_ex_i,
   input  logic [1:0]  data_type_ex_i,
   input  logic        data_sign_ext_ex_i,
   input  logic [31:0] adder_result_ex_i,
   input  logic [31:0] data_wdata_ex_i,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic        data_err_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic [31:0] data_rdata_i,
   output logic [31:0] data_rdata_ex_o,
   output logic        data_valid_o,
   output logic        lsu_ready_ex_o,
   output logic        busy_o,
   output logic        load_err_o,
   output logic        store_err_o,
   output logic        misaligned_err_o
);

   lsu_state_e  state;
   logic [29:0] addr_q;
   logic [1:0]  off_q, type_q;
   logic        sign_q, we_q;
   logic [31:0] wdata_q;
   logic        idle, mis, second, wait_rv, split, done;
   logic [1:0]  off, dtype;
   logic [31:0] wdata, rdata_lo;

   assign idle  = state == IDLE;
   assign off   = idle ? adder_result_ex_i[1:0] : off_q;
   assign dtype = idle ? data_type_ex_i : type_q;
   assign wdata = idle ? data_wdata_ex_i : wdata_q;
   assign mis   = dtype == DT_HALF ? off == 2'd3 : dtype == DT_BYTE ? 1'b0 : off != 2'd0;

`ifdef ZERORISCY_LSU_MISALIGNED_EN
   logic        mis_q;
   logic [31:0] rdata_q;

   assign second           = state inside {WAIT_GNT_MIS, WAIT_RVALID_MIS};
   assign rdata_lo         = second ? rdata_q : data_rdata_i;
   assign wait_rv          = state inside {WAIT_RVALID, WAIT_RVALID_MIS};
   assign split            = state == WAIT_RVALID && mis_q && !data_err_i;
   assign misaligned_err_o = 1'b0;
   assign data_req_o       = idle ? data_req_ex_i : state inside {WAIT_GNT, WAIT_GNT_MIS};
`else
   assign second           = 1'b0;
   assign rdata_lo         = data_rdata_i;
   assign wait_rv          = state == WAIT_RVALID;
   assign split            = 1'b0;
   assign misaligned_err_o = idle && data_req_ex_i && mis;
   assign data_req_o       = idle ? data_req_ex_i && !mis : state == WAIT_GNT;
`endif

   // split marks a clean first half: the access carries on, so nothing completes
   assign done           = wait_rv && data_rvalid_i && !split;
   assign data_valid_o   = done && !data_err_i;
   assign load_err_o     = done && data_err_i && !we_q;
   assign store_err_o    = done && data_err_i && we_q;
   assign lsu_ready_ex_o = done || misaligned_err_o || (idle && !data_req_ex_i);
   assign busy_o         = !idle;
   assign data_addr_o    = {idle ? adder_result_ex_i[31:2] : addr_q + {29'b0, second}, 2'b00};
   assign data_we_o      = idle ? data_we_ex_i : we_q;

   zeroriscy_lsu_align u_align (
      .off       (off),
      .data_type (dtype),
      .sign_ext  (sign_q),
      .second    (second),
      .wdata     (wdata),
      .rdata_hi  (data_rdata_i),
      .rdata_lo  (rdata_lo),
      .be        (data_be_o),
      .wdata_rot (data_wdata_o),
      .rdata_ext (data_rdata_ex_o)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         off_q   <= '0;
         type_q  <= DT_WORD;
         sign_q  <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
`ifdef ZERORISCY_LSU_MISALIGNED_EN
         mis_q   <= 1'b0;
         rdata_q <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (data_req_o) begin
               addr_q  <= adder_result_ex_i[31:2];
               off_q   <= adder_result_ex_i[1:0];
               type_q  <= data_type_ex_i;
               sign_q  <= data_sign_ext_ex_i;
               we_q    <= data_we_ex_i;
               wdata_q <= data_wdata_ex_i;
`ifdef ZERORISCY_LSU_MISALIGNED_EN
               mis_q   <= mis;
`endif
               state   <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end
            WAIT_GNT: if (data_gnt_i) state <= WAIT_RVALID;
`ifdef ZERORISCY_LSU_MISALIGNED_EN
            WAIT_RVALID: if (data_rvalid_i) begin
               state <= split ? WAIT_GNT_MIS : IDLE;
               if (split) rdata_q <= data_rdata_i;
            end
            WAIT_GNT_MIS: if (data_gnt_i) state <= WAIT_RVALID_MIS;
            WAIT_RVALID_MIS: if (data_rvalid_i) state <= IDLE;
`else
            WAIT_RVALID: if (data_rvalid_i) state <= IDLE;
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_zeroriscy_lsu_ctrl.sv
// tb_zeroriscy_lsu_ctrl: directed and random accesses checked against a byte-level memory model.
module tb_zeroriscy_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        data_req_ex_i = 1'b0, data_we_ex_i = 1'b0, data_sign_ext_ex_i = 1'b0;
   logic [1:0]  data_type_ex_i = 2'b00;
   logic [31:0] adder_result_ex_i = '0, data_wdata_ex_i = '0;
   logic        data_req_o, data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_ex_o;
   logic [31:0] data_rdata_i = '0;
   logic        data_we_o, data_valid_o, lsu_ready_ex_o, busy_o;
   logic [3:0]  data_be_o;
   logic        load_err_o, store_err_o, misaligned_err_o;
   int          total = 0, bad = 0;

`ifdef ZERORISCY_LSU_MISALIGNED_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   zeroriscy_lsu_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .data_req_ex_i(data_req_ex_i), .data_we_ex_i(data_we_ex_i),
      .data_type_ex_i(data_type_ex_i), .data_sign_ext_ex_i(data_sign_ext_ex_i),
      .adder_result_ex_i(adder_result_ex_i), .data_wdata_ex_i(data_wdata_ex_i),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
      .data_err_i(data_err_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
      .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
      .data_rdata_ex_o(data_rdata_ex_o), .data_valid_o(data_valid_o),
      .lsu_ready_ex_o(lsu_ready_ex_o), .busy_o(busy_o), .load_err_o(load_err_o),
      .store_err_o(store_err_o), .misaligned_err_o(misaligned_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete access; bytes seen on the bus are collected and the load result
   // is assembled byte by byte from them.
   task automatic access(input logic [31:0] addr, input logic [1:0] ty, input logic sg,
                         input logic we, input logic [31:0] wd, input logic [31:0] rd0,
                         input logic [31:0] rd1, input int gd, input int rdl, input int err_part);
      int          n, off, parts;
      bit          crossing, stop;
      logic [7:0]  b [8];
      logic [31:0] w, ebe, ewd, res;
      n = ty == 2'b00 ? 4 : ty == 2'b01 ? 2 : 1;
      off = int'(addr[1:0]);
      crossing = off + n > 4;
      stop = 1'b0;
      for (int i = 0; i < 8; i++) b[i] = 8'h00;
      @(negedge clk);
      data_req_ex_i = 1'b1; adder_result_ex_i = addr; data_type_ex_i = ty;
      data_sign_ext_ex_i = sg; data_we_ex_i = we; data_wdata_ex_i = wd;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      if (crossing && !MIS_EN) begin
         #1;
         chk("mis_req", data_req_o, 0);
         chk("mis_err", misaligned_err_o, 1);
         chk("mis_rdy", lsu_ready_ex_o, 1);
         @(negedge clk);
         data_req_ex_i = 1'b0;
         #1;
         chk("mis_clr", {misaligned_err_o, busy_o, data_req_o}, 0);
         return;
      end
      parts = crossing ? 2 : 1;
      for (int p = 0; p < parts && !stop; p++) begin
         w = {addr[31:2], 2'b00} + 32'(4 * p);
         ebe = '0;
         for (int j = 0; j < 4; j++) begin
            if (w + 32'(j) >= addr && w + 32'(j) < addr + 32'(n)) ebe[j] = 1'b1;
            ewd[8*j +: 8] = wd[8*((j - off + 4) % 4) +: 8];
         end
         for (int k = 0; k <= gd; k++) begin
            if (p > 0 || k > 0) @(negedge clk);
            data_gnt_i = (k == gd); data_rvalid_i = (k < gd); data_err_i = 1'b0;
            data_rdata_i = $urandom;
            #1;
            chk("req", data_req_o, 1);
            chk("addr", data_addr_o, w);
            chk("be", data_be_o, ebe);
            chk("we", data_we_o, we);
            if (we) chk("wdata", data_wdata_o, ewd);
            chk("rdy_gnt", lsu_ready_ex_o, 0);
            chk("valid_gnt", data_valid_o, 0);
         end
         for (int k = 1; k <= rdl; k++) begin
            @(negedge clk);
            data_gnt_i = 1'b0; data_rvalid_i = (k == rdl);
            data_rdata_i = k == rdl ? (p == 0 ? rd0 : rd1) : $urandom;
            data_err_i = (k == rdl) && err_part == p;
            #1;
            chk("busy", busy_o, 1);
            chk("req_wait", data_req_o, 0);
            if (k < rdl) chk("rdy_wait", lsu_ready_ex_o, 0);
         end
         for (int j = 0; j < 4; j++) b[4*p + j] = data_rdata_i[8*j +: 8];
         if (err_part == p) begin
            chk("load_err", load_err_o, !we);
            chk("store_err", store_err_o, we);
            chk("valid_err", data_valid_o, 0);
            chk("rdy_err", lsu_ready_ex_o, 1);
            stop = 1'b1;
         end else if (p == parts - 1) begin
            res = '0;
            for (int i = 0; i < 4; i++)
               res[8*i +: 8] = i < n ? b[off + i] : (sg && b[off + n - 1][7]) ? 8'hFF : 8'h00;
            chk("valid", data_valid_o, 1);
            chk("rdy_done", lsu_ready_ex_o, 1);
            chk("errs_done", {load_err_o, store_err_o}, 0);
            if (!we) chk("rdata", data_rdata_ex_o, res);
         end else begin
            chk("valid_half", data_valid_o, 0);
            chk("rdy_half", lsu_ready_ex_o, 0);
         end
      end
      @(negedge clk);
      data_req_ex_i = 1'b0; data_rvalid_i = 1'b1; data_err_i = 1'b1; data_gnt_i = 1'b0;
      #1;
      chk("idle_busy", busy_o, 0);
      chk("idle_pulses", {data_valid_o, load_err_o, store_err_o}, 0);
      chk("idle_req", data_req_o, 0);
      chk("idle_rdy", lsu_ready_ex_o, 1);
      data_rvalid_i = 1'b0; data_err_i = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_pulses", {data_valid_o, load_err_o, store_err_o, misaligned_err_o}, 0);
      rst_n = 1'b1;
      access(32'h100, 2'b00, 0, 0, 0, 32'hDEADBEEF, 0, 0, 2, -1);
      access(32'h103, 2'b10, 1, 0, 0, 32'h80000000, 0, 1, 1, -1);
      access(32'h103, 2'b10, 0, 0, 0, 32'h80000000, 0, 0, 1, -1);
      access(32'h102, 2'b01, 0, 1, 32'h0000ABCD, 0, 0, 3, 1, -1);
      access(32'h101, 2'b00, 0, 0, 0, 32'h332211AA, 32'h55667744, 0, 1, -1);
      access(32'h102, 2'b00, 0, 0, 0, 32'h12345678, 32'h9ABCDEF0, 1, 2, -1);
      access(32'h104, 2'b00, 0, 1, 32'hCAFEF00D, 0, 0, 1, 2, 0);
      access(32'h107, 2'b01, 1, 0, 0, 32'h11223344, 32'h556677AA, 2, 1, 0);
      // reset while waiting for rvalid abandons the access silently
      @(negedge clk);
      data_req_ex_i = 1'b1; adder_result_ex_i = 32'h200; data_type_ex_i = 2'b00;
      data_we_ex_i = 1'b0; data_gnt_i = 1'b1;
      @(negedge clk);
      data_gnt_i = 1'b0;
      #1;
      chk("pre_rst_busy", busy_o, 1);
      rst_n = 1'b0; data_req_ex_i = 1'b0; data_rvalid_i = 1'b1;
      #1;
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_pulses", {data_valid_o, load_err_o, store_err_o}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_pulses", {data_valid_o, load_err_o, store_err_o, busy_o}, 0);
      data_rvalid_i = 1'b0;
      for (int t = 0; t < 60; t++) begin
         logic [1:0] ty;
         ty = 2'($urandom_range(0, 2));
         access($urandom_range(32'h0, 32'hFFFF), ty, 1'($urandom), 1'($urandom), $urandom,
                $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
                ($urandom % 6 == 0) ? int'($urandom_range(0, 1)) : -1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/zeroriscy_lsu_ctrl.md
ZERORISCY_LSU_CTRL -- requirements
Module: zeroriscy_lsu_ctrl

Interface
REQ-001 SHALL have parameter: none; all options via Configuration macro.
REQ-002 SHALL have ports: clk  in  1  core clock; rst_n  in  1  async active-low reset.
REQ-003 SHALL have ports: data_req_ex_i  in  1  EX requests memory access; data_we_ex_i  in  1  1=store.
REQ-004 SHALL have ports: data_type_ex_i  in  2  00 word, 01 half, 10 byte; data_sign_ext_ex_i  in  1  sign-extend load.
REQ-005 SHALL have ports: adder_result_ex_i  in  32  byte address from EX adder; data_wdata_ex_i  in  32  store data (LSB-aligned).
REQ-006 SHALL have ports: data_req_o  out  1; data_gnt_i  in  1; data_rvalid_i  in  1; data_err_i  in  1; data_addr_o  out  32 (word-aligned); data_we_o  out  1; data_be_o  out  4; data_wdata_o  out  32; data_rdata_i  in  32.
REQ-007 SHALL have ports: data_rdata_ex_o  out  32  extended load result; data_valid_o  out  1  access completed OK; lsu_ready_ex_o  out  1  EX may advance; busy_o  out  1  state != IDLE.
REQ-008 SHALL have ports: load_err_o  out  1; store_err_o  out  1; misaligned_err_o  out  1; all 1-cycle pulses.
REQ-009 SHALL use one clock, clk; reset rst_n asynchronous, active-low.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RVALID, WAIT_GNT_MIS, WAIT_RVALID_MIS; one outstanding bus transaction max.
REQ-011 SHALL in IDLE drive data_req_o = data_req_ex_i combinationally; gnt same cycle -> WAIT_RVALID, else -> WAIT_GNT.
REQ-012 SHALL hold data_req_o, addr, we, be, wdata stable from request until data_gnt_i; WAIT_GNT + gnt -> WAIT_RVALID.
REQ-013 SHALL ignore data_rvalid_i outside WAIT_RVALID/WAIT_RVALID_MIS.
REQ-014 SHALL on rvalid in WAIT_RVALID: pulse data_valid_o (no err) or load_err_o/store_err_o (err), assert lsu_ready_ex_o, return IDLE; a new request MAY issue that same cycle only from IDLE next cycle.
REQ-015 SHALL hold lsu_ready_ex_o = 0 whenever data_req_ex_i=1 and access not completing this cycle; 1 when no request pending.
REQ-016 SHALL compute offset = addr[1:0]; data_be_o = word 1111<<off, half 0011<<off, byte 0001<<off (truncated to 4 bits); data_wdata_o = wdata rotated left by 8*off.
REQ-017 SHALL treat word with off!=0 and half with off=3 as misaligned.
REQ-018 SHALL extract load data as ({rdata_i, rdata_q} or {rdata_i,rdata_i} when aligned) >> 8*off, then zero/sign-extend per type and data_sign_ext_ex_i; word ignores sign flag.
REQ-019 SHALL register addr offset, type, sign, we at first grant so outputs are independent of EX inputs afterwards.

Reset
REQ-020 SHALL on rst_n low: state IDLE, rdata_q 0, all pulse outputs 0, busy_o 0, data_valid_o 0; reset mid-transaction abandons it with no completion pulse.

Configuration
REQ-021 SHALL honour macro ZERORISCY_LSU_MISALIGNED_EN.
REQ-022 SHALL with macro defined split misaligned access: first part at addr&~3 (be per REQ-016), rvalid without err -> store rdata_q, -> WAIT_GNT_MIS; second part at (addr&~3)+4, be = 1111>>(4-off) word, 0001 half, wdata same rotation; completion per REQ-014 from WAIT_RVALID_MIS.
REQ-023 SHALL with macro defined abort on err in first part: error pulse, no second request, IDLE.
REQ-024 SHALL without macro issue no bus request for misaligned access; pulse misaligned_err_o and lsu_ready_ex_o in the request cycle; *_MIS states absent.

Structure
REQ-025 SHALL place lsu_state_e and data-type codes (DT_WORD, DT_HALF, DT_BYTE) in zeroriscy_defines.
REQ-026 SHALL put byte-enable, wdata rotation and load extraction in combinational sub-module zeroriscy_lsu_align.

Verification
REQ-027 SHALL cover: LW 0x100, gnt same cycle, rvalid +2, rdata 0xDEADBEEF -> data_rdata_ex_o 0xDEADBEEF, data_valid_o 1 cycle.
REQ-028 SHALL cover: LB signed 0x103, rdata 0x80000000 -> be 1000, result 0xFFFFFF80; LBU -> 0x00000080.
REQ-029 SHALL cover: SH 0x102 wdata 0x0000ABCD, gnt delayed 3 cycles -> be 1100, wdata 0xABCD0000 held stable until gnt.
REQ-030 SHALL cover (macro on): LW 0x101, rdata 0x332211XX then 0xXXXXXX44 -> two requests 0x100/0x104, be 1110/0001, result 0x44332211.
REQ-031 SHALL cover (macro off): LW 0x102 -> data_req_o 0, misaligned_err_o pulse, lsu_ready_ex_o 1 same cycle.
REQ-032 SHALL cover: store rvalid with data_err_i -> store_err_o pulse, no data_valid_o; rst_n low in WAIT_RVALID -> IDLE, no pulses.
